// File: rtl/vga_pkg.sv
// Shared VGA/mouse definitions: coordinate width, screen limits, cursor size
// and the click-detection state encoding.
package vga_pkg;

  localparam int unsigned POS_W     = 12;
  localparam int unsigned X_MAX_DEF = 1011;
  localparam int unsigned Y_MAX_DEF = 751;
  localparam int unsigned CURSOR_W  = 12;
  localparam int unsigned CURSOR_H  = 20;

  typedef enum logic [1:0] {
    CLICK_IDLE    = 2'd0,
    CLICK_PRESSED = 2'd1,
    CLICK_PENDING = 2'd2
  } click_state_e;

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchronizer followed by a stability counter; the held level only
// follows the input once it has disagreed for DEB_CYCLES consecutive samples.
module btn_debounce #(
  parameter int unsigned DEB_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_in,
  output logic btn_held
);

  localparam int unsigned CNT_W = $clog2(DEB_CYCLES) + 1;

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             held_q, held_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      held_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      held_q  <= held_d;
      cnt_q   <= cnt_d;
    end
  end

  // Count only while the synced level disagrees with the accepted level.
  always_comb begin
    sync1_d = btn_in;
    sync2_d = sync1_q;
    held_d  = held_q;
    cnt_d   = '0;
    if (sync2_q != held_q) begin
      if (cnt_q == CNT_W'(DEB_CYCLES - 1)) begin
        held_d = ~held_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  assign btn_held = held_q;

endmodule

// File: rtl/mouse_frame_sync.sv
// Frame-synchronous mouse front end: clamps and latches the cursor position
// once per frame and turns debounced left-button presses into frame-aligned clicks.
module mouse_frame_sync
  import vga_pkg::*;
#(
  parameter int unsigned X_MAX      = X_MAX_DEF,
  parameter int unsigned Y_MAX      = Y_MAX_DEF,
  parameter int unsigned DEB_CYCLES = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [POS_W-1:0] xpos_in,
  input  logic [POS_W-1:0] ypos_in,
  input  logic             left_in,
  input  logic             vblnk,
  output logic [POS_W-1:0] xpos,
  output logic [POS_W-1:0] ypos,
  output logic             left_held,
  output logic             left_click,
  output logic             frame_tick
);

  logic             vblnk_q, vblnk_d;
  logic             vblnk_q2, vblnk_d2;
  logic [POS_W-1:0] xin_q, xin_d;
  logic [POS_W-1:0] yin_q, yin_d;
  logic [POS_W-1:0] xpos_q, xpos_d;
  logic [POS_W-1:0] ypos_q, ypos_d;
  logic             frame_tick_q, frame_tick_d;
  logic             left_click_q, left_click_d;
  logic             held_prev_q, held_prev_d;
  click_state_e     state_q, state_d;
  logic             held;
  logic             tick_c;
  logic             held_rise_c;
  logic             held_fall_c;

  btn_debounce #(
    .DEB_CYCLES (DEB_CYCLES)
  ) u_left_deb (
    .clk      (clk),
    .rst      (rst),
    .btn_in   (left_in),
    .btn_held (held)
  );

  // vblnk pipeline resets high so a blanking interval already in progress
  // at reset release is not mistaken for a new frame.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vblnk_q      <= 1'b1;
      vblnk_q2     <= 1'b1;
      xin_q        <= '0;
      yin_q        <= '0;
      xpos_q       <= '0;
      ypos_q       <= '0;
      frame_tick_q <= 1'b0;
      left_click_q <= 1'b0;
      held_prev_q  <= 1'b0;
      state_q      <= CLICK_IDLE;
    end else begin
      vblnk_q      <= vblnk_d;
      vblnk_q2     <= vblnk_d2;
      xin_q        <= xin_d;
      yin_q        <= yin_d;
      xpos_q       <= xpos_d;
      ypos_q       <= ypos_d;
      frame_tick_q <= frame_tick_d;
      left_click_q <= left_click_d;
      held_prev_q  <= held_prev_d;
      state_q      <= state_d;
    end
  end

  assign tick_c      = vblnk_q & ~vblnk_q2;
  assign held_rise_c = held & ~held_prev_q;
  assign held_fall_c = ~held & held_prev_q;

  // Position clamp/latch and click FSM next-state.
  always_comb begin
    vblnk_d      = vblnk;
    vblnk_d2     = vblnk_q;
    xin_d        = xpos_in;
    yin_d        = ypos_in;
    xpos_d       = xpos_q;
    ypos_d       = ypos_q;
    frame_tick_d = tick_c;
    left_click_d = 1'b0;
    held_prev_d  = held;
    state_d      = state_q;

    if (tick_c) begin
      xpos_d = (xin_q > POS_W'(X_MAX)) ? POS_W'(X_MAX) : xin_q;
      ypos_d = (yin_q > POS_W'(Y_MAX)) ? POS_W'(Y_MAX) : yin_q;
    end

    unique case (state_q)
      CLICK_IDLE: begin
        if (held_rise_c) state_d = CLICK_PRESSED;
      end
      CLICK_PRESSED: begin
        if (held_fall_c) state_d = CLICK_PENDING;
      end
      CLICK_PENDING: begin
        // A press starting on the emit cycle is carried straight into PRESSED.
        if (tick_c) begin
          left_click_d = 1'b1;
          state_d      = held_rise_c ? CLICK_PRESSED : CLICK_IDLE;
        end
      end
      default: state_d = CLICK_IDLE;
    endcase
  end

  assign xpos       = xpos_q;
  assign ypos       = ypos_q;
  assign left_held  = held;
  assign left_click = left_click_q;
  assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_mouse_frame_sync.sv
// Randomized self-checking bench for mouse_frame_sync against a cycle-level
// behavioural model built from input histories and press/release bookkeeping.
module tb_mouse_frame_sync;

  localparam int unsigned XM  = 1011;
  localparam int unsigned YM  = 751;
  localparam int unsigned DEB = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [11:0] xpos_in = '0;
  logic [11:0] ypos_in = '0;
  logic        left_in = 1'b0;
  logic        vblnk   = 1'b1;
  logic [11:0] xpos, ypos;
  logic        left_held, left_click, frame_tick;

  mouse_frame_sync #(
    .X_MAX      (XM),
    .Y_MAX      (YM),
    .DEB_CYCLES (DEB)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .xpos_in    (xpos_in),
    .ypos_in    (ypos_in),
    .left_in    (left_in),
    .vblnk      (vblnk),
    .xpos       (xpos),
    .ypos       (ypos),
    .left_held  (left_held),
    .left_click (left_click),
    .frame_tick (frame_tick)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int clicks  = 0;

  // Model state: input samples from earlier edges plus expected outputs.
  bit          vb_ago1, vb_ago2;
  logic [11:0] x_ago1, y_ago1;
  bit          raw_ago1, raw_ago2;
  int          run;
  bit          rose_last, fell_last;
  bit          have_press, have_click;
  logic [11:0] e_x, e_y;
  bit          e_held, e_tick, e_click;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [11:0] clamp(input logic [11:0] v, input int unsigned lim);
    return (int'(v) > int'(lim)) ? 12'(lim) : v;
  endfunction

  function automatic void model_reset();
    vb_ago1 = 1'b1; vb_ago2 = 1'b1;
    x_ago1 = '0; y_ago1 = '0;
    raw_ago1 = 1'b0; raw_ago2 = 1'b0;
    run = 0;
    rose_last = 1'b0; fell_last = 1'b0;
    have_press = 1'b0; have_click = 1'b0;
    e_x = '0; e_y = '0;
    e_held = 1'b0; e_tick = 1'b0; e_click = 1'b0;
  endfunction

  function automatic void model_edge();
    bit tick, prev_held;
    tick = vb_ago1 && !vb_ago2;
    vb_ago2 = vb_ago1;
    vb_ago1 = vblnk;
    if (tick) begin
      e_x = clamp(x_ago1, XM);
      e_y = clamp(y_ago1, YM);
    end
    x_ago1 = xpos_in;
    y_ago1 = ypos_in;

    e_click = 1'b0;
    if (have_click) begin
      if (tick) begin
        e_click    = 1'b1;
        have_click = 1'b0;
        have_press = rose_last;
      end
    end else if (have_press) begin
      if (fell_last) begin
        have_press = 1'b0;
        have_click = 1'b1;
      end
    end else if (rose_last) begin
      have_press = 1'b1;
    end

    // Accept a new level after DEB consecutive disagreeing synced samples.
    prev_held = e_held;
    if (raw_ago2 != e_held) begin
      run++;
      if (run == int'(DEB)) begin
        e_held = !e_held;
        run    = 0;
      end
    end else begin
      run = 0;
    end
    rose_last = e_held && !prev_held;
    fell_last = !e_held && prev_held;
    raw_ago2  = raw_ago1;
    raw_ago1  = left_in;
    e_tick    = tick;
  endfunction

  task automatic step();
    @(posedge clk);
    if (!rst) model_reset();
    else model_edge();
    #1;
    if (left_click === 1'b1) clicks++;
    check_val("frame_tick", 32'(frame_tick), 32'(e_tick));
    check_val("xpos", 32'(xpos), 32'(e_x));
    check_val("ypos", 32'(ypos), 32'(e_y));
    check_val("left_held", 32'(left_held), 32'(e_held));
    check_val("left_click", 32'(left_click), 32'(e_click));
  endtask

  task automatic run_cycles(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic frame(input int hi, input int lo);
    vblnk = 1'b1;
    run_cycles(hi);
    vblnk = 1'b0;
    run_cycles(lo);
  endtask

  function automatic logic [11:0] pick_pos(input int unsigned lim);
    case ($urandom_range(0, 4))
      0:       return 12'(lim);
      1:       return 12'(lim + 1);
      2:       return 12'd0;
      3:       return 12'hFFF;
      default: return 12'($urandom_range(0, 4095));
    endcase
  endfunction

  initial begin
    int rise_at;
    int c0;
    int seg;
    model_reset();

    // Reset with vblnk already high, then release: no spurious tick.
    run_cycles(3);
    rst = 1'b1;
    run_cycles(6);
    check_val("no_tick_after_rst", 32'(frame_tick), 32'd0);
    vblnk = 1'b0;
    run_cycles(4);

    // Frame latch latency and mid-frame hold.
    xpos_in = 12'd500; ypos_in = 12'd300;
    run_cycles(2);
    vblnk = 1'b1;
    run_cycles(2);
    check_val("xpos_2cyc", 32'(xpos), 32'd500);
    check_val("ypos_2cyc", 32'(ypos), 32'd300);
    xpos_in = 12'd600;
    run_cycles(6);
    check_val("xpos_hold", 32'(xpos), 32'd500);
    vblnk = 1'b0;
    run_cycles(5);
    frame(4, 10);
    check_val("xpos_next", 32'(xpos), 32'd600);

    // Clamp above and at the limits.
    xpos_in = 12'd1500; ypos_in = 12'd4095;
    frame(4, 10);
    check_val("xclamp", 32'(xpos), 32'(XM));
    check_val("yclamp", 32'(ypos), 32'(YM));
    xpos_in = 12'(XM); ypos_in = 12'(YM);
    frame(4, 10);
    check_val("xexact", 32'(xpos), 32'(XM));
    check_val("yexact", 32'(ypos), 32'(YM));

    // Short glitch is rejected.
    c0 = clicks;
    left_in = 1'b1;
    run_cycles(10);
    left_in = 1'b0;
    run_cycles(30);
    frame(3, 10);
    check_val("glitch_clicks", 32'(clicks - c0), 32'd0);

    // Long press: held rises 18 edges after the input edge; one click at frame.
    left_in = 1'b1;
    rise_at = 0;
    for (int i = 1; i <= 40; i++) begin
      step();
      if (left_held === 1'b1 && rise_at == 0) rise_at = i;
    end
    check_val("held_latency", 32'(rise_at), 32'd18);
    left_in = 1'b0;
    run_cycles(30);
    c0 = clicks;
    frame(3, 10);
    check_val("one_click", 32'(clicks - c0), 32'd1);

    // Two presses in one frame give a single click.
    for (int k = 0; k < 2; k++) begin
      left_in = 1'b1; run_cycles(30);
      left_in = 1'b0; run_cycles(30);
    end
    c0 = clicks;
    frame(3, 10);
    frame(3, 10);
    check_val("two_press_one_click", 32'(clicks - c0), 32'd1);

    // Reset while a click is pending discards it.
    left_in = 1'b1; run_cycles(30);
    left_in = 1'b0; run_cycles(30);
    vblnk = 1'b1;
    rst = 1'b0;
    #1;
    check_val("rst_xpos", 32'(xpos), 32'd0);
    check_val("rst_held", 32'(left_held), 32'd0);
    run_cycles(3);
    rst = 1'b1;
    c0 = clicks;
    run_cycles(5);
    vblnk = 1'b0;
    run_cycles(5);
    frame(3, 10);
    check_val("rst_no_click", 32'(clicks - c0), 32'd0);

    // Randomized frames with random position and button segments.
    seg = 1;
    for (int f = 0; f < 50; f++) begin
      int hi, lo;
      hi = $urandom_range(2, 8);
      lo = $urandom_range(4, 40);
      for (int c = 0; c < hi + lo; c++) begin
        vblnk = (c < hi);
        if ($urandom_range(0, 7) == 0) xpos_in = pick_pos(XM);
        if ($urandom_range(0, 7) == 0) ypos_in = pick_pos(YM);
        seg--;
        if (seg == 0) begin
          left_in = ~left_in;
          seg = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 20))
                                            : int'($urandom_range(15, 60));
        end
        step();
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
